// File: rtl/cv32e40p_tb_exit_monitor_if.sv
// Event bundle from the monitored cores to the exit monitor.
//   pass       : per-channel tests-passed pulse or level
//   fail       : per-channel tests-failed
//   exit_valid : per-channel exit strobe
//   exit_value : per-channel exit code, channel c in bits [32c+31:32c]
// master = core side (drives events), slave = monitor side.
interface cv32e40p_tb_exit_monitor_if #(
    parameter int unsigned NUM_CH = 1
);
    logic [NUM_CH-1:0]    pass;
    logic [NUM_CH-1:0]    fail;
    logic [NUM_CH-1:0]    exit_valid;
    logic [32*NUM_CH-1:0] exit_value;

    modport master (output pass, output fail, output exit_valid, output exit_value);
    modport slave  (input  pass, input  fail, input  exit_valid, input  exit_value);
endinterface

// File: rtl/cv32e40p_tb_exit_monitor.sv
// Multi-channel pass/fail/exit arbiter with a programmable cycle-limit watchdog.
// Reports one final status after a drain delay.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   enable_i        : run enable; counting and event sampling only while high
//   max_cycles_i    : cycle limit, 0 = unlimited
//   ev_if           : per-channel pass/fail/exit events (slave modport)
//   cycle_cnt_o     : enabled cycles elapsed in RUN (freezes on termination)
//   done_o          : run finished, sticky until reset
//   status_o        : 0 RUNNING, 1 PASS, 2 FAIL, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT
//   chan_o          : deciding channel index
//   exit_value_o    : exit code of the deciding channel (EXIT_* only)
//   chan_done_o     : per-channel "has reported" flags
module cv32e40p_tb_exit_monitor #(
    parameter  int unsigned NUM_CH       = 1,
    parameter  int unsigned CNT_WIDTH    = 32,
    parameter  int unsigned DRAIN_CYCLES = 4,
    parameter  int unsigned WAIT_ALL     = 0,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [CNT_WIDTH-1:0]    max_cycles_i,
    cv32e40p_tb_exit_monitor_if.slave ev_if,
    output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
    output logic                    done_o,
    output logic [2:0]              status_o,
    output logic [CH_W-1:0]         chan_o,
    output logic [31:0]             exit_value_o,
    output logic [NUM_CH-1:0]       chan_done_o
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;
    typedef enum logic [2:0] {
        ST_RUNNING  = 3'd0,
        ST_PASS     = 3'd1,
        ST_FAIL     = 3'd2,
        ST_EXIT_OK  = 3'd3,
        ST_EXIT_ERR = 3'd4,
        ST_TIMEOUT  = 3'd5
    } status_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 done_q, done_d;
    status_e              status_q, status_d;
    logic [CH_W-1:0]      chan_q, chan_d;
    logic [31:0]          xval_q, xval_d;
    logic [NUM_CH-1:0]    cdone_q, cdone_d;
    logic                 pass_seen_q, pass_seen_d;

    // Per-cycle arbitration scratch
    status_e              cls;
    logic                 found_new;
    logic [CH_W-1:0]      first_ch;
    logic                 term_hit;
    status_e              term_st;
    logic [CH_W-1:0]      term_ch;
    logic [31:0]          term_val;
    logic                 finish;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            drain_q     <= '0;
            done_q      <= 1'b0;
            status_q    <= ST_RUNNING;
            chan_q      <= '0;
            xval_q      <= '0;
            cdone_q     <= '0;
            pass_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            status_q    <= status_d;
            chan_q      <= chan_d;
            xval_q      <= xval_d;
            cdone_q     <= cdone_d;
            pass_seen_q <= pass_seen_d;
        end
    end

    // Next-state: event classification, arbitration, watchdog, drain
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        done_d      = done_q;
        status_d    = status_q;
        chan_d      = chan_q;
        xval_d      = xval_q;
        cdone_d     = cdone_q;
        pass_seen_d = pass_seen_q;
        cls         = ST_RUNNING;
        found_new   = 1'b0;
        first_ch    = '0;
        term_hit    = 1'b0;
        term_st     = ST_RUNNING;
        term_ch     = '0;
        term_val    = '0;
        finish      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (enable_i) begin
                    // Ascending scan so the first hit is the lowest index
                    for (int c = 0; c < NUM_CH; c++) begin
                        cls = ST_RUNNING;
                        if (!cdone_q[c]) begin
                            if (ev_if.fail[c])
                                cls = ST_FAIL;
                            else if (ev_if.exit_valid[c])
                                cls = (ev_if.exit_value[32*c +: 32] == 32'd0) ? ST_EXIT_OK : ST_EXIT_ERR;
                            else if (ev_if.pass[c])
                                cls = ST_PASS;
                        end
                        if (cls != ST_RUNNING) begin
                            cdone_d[c] = 1'b1;
                            if (cls == ST_PASS) pass_seen_d = 1'b1;
                            if (!found_new) begin
                                found_new = 1'b1;
                                first_ch  = CH_W'(c);
                            end
                            if (!term_hit && (WAIT_ALL == 0 || cls == ST_FAIL || cls == ST_EXIT_ERR)) begin
                                term_hit = 1'b1;
                                term_st  = cls;
                                term_ch  = CH_W'(c);
                                term_val = (cls == ST_EXIT_ERR || cls == ST_EXIT_OK) ?
                                           ev_if.exit_value[32*c +: 32] : 32'd0;
                            end
                        end
                    end
                    // Last outstanding channel reported without an error
                    if (!term_hit && WAIT_ALL != 0 && found_new && (&cdone_d)) begin
                        term_hit = 1'b1;
                        term_st  = pass_seen_d ? ST_PASS : ST_EXIT_OK;
                        term_ch  = first_ch;
                        term_val = 32'd0;
                    end

                    if (term_hit) begin
                        finish   = 1'b1;
                        status_d = term_st;
                        chan_d   = term_ch;
                        xval_d   = term_val;
                    end else if (max_cycles_i != '0 && cnt_q >= max_cycles_i) begin
                        finish   = 1'b1;
                        status_d = ST_TIMEOUT;
                        chan_d   = '0;
                        xval_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end

                    if (finish) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign cycle_cnt_o  = cnt_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign chan_o       = chan_q;
    assign exit_value_o = xval_q;
    assign chan_done_o  = cdone_q;

endmodule

// File: doc/cv32e40p_tb_exit_monitor.md
# cv32e40p_tb_exit_monitor

Synthesizable, multi-channel successor to the bench's pass/fail/exit checker and cycle-limit watchdog. It monitors NUM_CH cores or harts and arbitrates their pass, fail and exit events. It enforces a run-time programmable cycle limit, then reports one final status after a drain delay. It sits between the core subsystem(s) and the bench top, so the top only watches `done_o`.

## Interface
- NUM_CH, 1: number of monitored channels (1..16).
- CNT_WIDTH, 32: cycle counter width.
- DRAIN_CYCLES, 4: cycles between the terminating event and `done_o`. 0 is allowed.
- WAIT_ALL, 0: 0 = first event ends the run; 1 = run ends on the first failure or when every channel has reported.

- clk_i  in  1  clock. Single clock domain.
- rst_ni  in  1  reset. Synchronous, active-low.
- enable_i  in  1  run enable (fetch-enable analogue). The counter and event sampling are active only while high.
- max_cycles_i  in  CNT_WIDTH  cycle limit. 0 = unlimited. Sampled every cycle.
- pass_i  in  NUM_CH  per-channel tests-passed pulse or level.
- fail_i  in  NUM_CH  per-channel tests-failed.
- exit_valid_i  in  NUM_CH  per-channel exit strobe.
- exit_value_i  in  32*NUM_CH  per-channel exit code. Channel c occupies bits [32c+31:32c].
- cycle_cnt_o  out  CNT_WIDTH  enabled cycles elapsed in RUN.
- done_o  out  1  run finished. Sticky until reset.
- status_o  out  3  0 RUNNING, 1 PASS, 2 FAIL, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT.
- chan_o  out  max(1,$clog2(NUM_CH))  deciding channel index.
- exit_value_o  out  32  exit code of the deciding channel (0 unless the decision is EXIT_*).
- chan_done_o  out  NUM_CH  per-channel "has reported" flags.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset enters RUN.
- RUN:
  - The counter increments on each cycle with `enable_i`=1 and saturates at all-ones.
  - When `enable_i`=0, events are ignored.
- Per-channel event classification, with priority fail > exit_valid > pass:
  - FAIL.
  - EXIT_OK if the exit value is 0; EXIT_ERR otherwise.
  - PASS.
- Each channel records only its first event. That event sets the channel's `chan_done_o` bit. Later events from a channel already marked done are ignored.
- Terminating events:
  - WAIT_ALL=0: any new channel event.
  - WAIT_ALL=1: a FAIL or EXIT_ERR, or the cycle in which the last outstanding channel reports.
- Several channels terminating in the same cycle: the lowest index wins.
- WAIT_ALL=1 all-reported completion:
  - `status_o` = PASS if any channel recorded PASS, else EXIT_OK.
  - `chan_o` = lowest-index channel reporting in that cycle.
- Timeout: a cycle in RUN with `max_cycles_i`≠0, `cycle_cnt_o` ≥ `max_cycles_i` and no terminating event.
  - Result is TIMEOUT, `chan_o`=0, `exit_value_o`=0.
  - A terminating event in the same cycle takes precedence over timeout.
- On termination:
  - `status_o`, `chan_o` and `exit_value_o` latch.
  - The counter freezes.
  - The FSM enters DRAIN, or DONE if DRAIN_CYCLES=0.
- DRAIN: a down-counter is loaded with DRAIN_CYCLES-1. At 0 the FSM goes to DONE.
- DRAIN and DONE ignore all inputs, including `enable_i`. `chan_done_o` is frozen in these states.
- DONE is absorbing until `rst_ni`=0.
- Reset asserted mid-run or mid-drain returns all state to reset values on that edge.

## Timing
- All outputs are registered.
- Reset values: `cycle_cnt_o`=0, `done_o`=0, `status_o`=0 (RUNNING), `chan_o`=0, `exit_value_o`=0, `chan_done_o`=0.
- Event sampled at edge t:
  - `status_o`, `chan_o`, `exit_value_o` and `chan_done_o` update at edge t.
  - `done_o` rises at edge t+DRAIN_CYCLES (at edge t if DRAIN_CYCLES=0).
- `cycle_cnt_o` after edge t equals the count of enabled RUN edges before t, plus 1 if t itself was enabled. The terminating edge does not count.
- Timeout fires at the first enabled edge where the pre-edge count ≥ limit.
  - Example: limit=3 gives TIMEOUT at edge 4 with `cycle_cnt_o`=3.

## Test plan
- NUM_CH=1, DRAIN_CYCLES=4: `pass_i` pulse after 10 enabled cycles -> `status_o`=1, `chan_o`=0, `cycle_cnt_o`=10; `done_o` rises 4 edges later.
- NUM_CH=4, WAIT_ALL=0: `exit_valid_i`[2] with value 7 and `pass_i`[1] in the same cycle -> `status_o`=1 (PASS, chan 1 wins). In a separate run, `exit_valid_i`[2] alone with value 7 -> `status_o`=4, `chan_o`=2, `exit_value_o`=7.
- NUM_CH=4, WAIT_ALL=1: pass on ch0, 1 and 3 at different cycles, exit 0 on ch2 last -> `status_o`=1, `chan_o`=2, `chan_done_o`=4'hF; `fail_i`[3] mid-run instead -> `status_o`=2, `chan_o`=3 immediately.
- `max_cycles_i`=3, no events -> `status_o`=5, `cycle_cnt_o`=3. `max_cycles_i`=0 for 1000 cycles -> still RUNNING. Limit reached in the same cycle as `fail_i` -> FAIL.
- `enable_i` toggling 1/0 with `pass_i` asserted only while low -> ignored and counter frozen; pass asserted while high -> accepted.
- `rst_ni` low during DRAIN, and again in DONE -> all outputs return to reset values next edge; a new run completes normally.
